// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad entry path: key code map, entry state
// encoding, pulse encoding and a key classifier used by the control FSM.
package keypad_pkg;

    // Key codes produced by the matrix-keypad decoder.
    localparam logic [3:0] KEY_NONE      = 4'hF;
    localparam logic [3:0] KEY_START     = 4'hA;
    localparam logic [3:0] KEY_CLEAR     = 4'hB;
    localparam logic [3:0] KEY_CONFIRM   = 4'hC;
    localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;

    // Entry state, one-hot so each state test is a single bit.
    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_ENTRY  = 4'b0010,
        ST_LOCKED = 4'b0100,
        ST_RUN    = 4'b1000
    } entry_state_e;

    // Key classes seen by the FSM after decoding a press event.
    typedef enum logic [2:0] {
        KC_DIGIT,
        KC_START,
        KC_CLEAR,
        KC_CONFIRM,
        KC_BAD
    } key_class_e;

    // The pulse outputs are carried as one encoded register, so two of them
    // can never be high in the same cycle.
    typedef enum logic [2:0] {
        PL_NONE,
        PL_VALID,
        PL_START,
        PL_STOP,
        PL_ERR
    } pulse_e;

    // Map a raw key code onto its class; 0xD and 0xE are undefined keys.
    function automatic key_class_e classify_key(input logic [3:0] code);
        key_class_e cls;
        if (code <= KEY_DIGIT_MAX) begin
            cls = KC_DIGIT;
        end else if (code == KEY_START) begin
            cls = KC_START;
        end else if (code == KEY_CLEAR) begin
            cls = KC_CLEAR;
        end else if (code == KEY_CONFIRM) begin
            cls = KC_CONFIRM;
        end else begin
            cls = KC_BAD;
        end
        return cls;
    endfunction

endpackage

// File: rtl/key_event_sync.sv
// Brings the asynchronous keypad code into the clk domain and turns a held or
// idle code into a single-cycle press event carrying the pressed code.
module key_event_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_code,
    output logic       press_evt,
    output logic [3:0] press_code
);
    import keypad_pkg::*;

    logic [3:0] s1_q, s1_d;
    logic [3:0] s2_q, s2_d;
    logic [3:0] prev_q, prev_d;
    logic       evt_q, evt_d;
    logic [3:0] code_q, code_d;
    logic       stable;

    // Next-state for the synchronizer, the last stable code and the event flop.
    always_comb begin
        // NOTE: each _d is given its default before any condition, so no branch leaves it unassigned and no latch is inferred.
        s1_d   = key_code;
        s2_d   = s1_q;
        prev_d = prev_q;
        evt_d  = 1'b0;
        code_d = code_q;
        // A code only counts once both synchronizer stages agree on it.
        stable = (s1_q == s2_q);
        if (stable) begin
            prev_d = s2_q;
            // Event on a change to a real key; a held key or a release never fires.
            if ((s2_q != prev_q) && (s2_q != KEY_NONE)) begin
                evt_d  = 1'b1;
                code_d = s2_q;
            end
        end
    end

    // State registers; reset parks everything at "no key".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q   <= KEY_NONE;
            s2_q   <= KEY_NONE;
            prev_q <= KEY_NONE;
            evt_q  <= 1'b0;
            code_q <= KEY_NONE;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its neighbours.
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
            evt_q  <= evt_d;
            code_q <= code_d;
        end
    end

    assign press_evt  = evt_q;
    assign press_code = code_q;

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: accumulates typed digits as BCD for the display
// and as binary for the car controller, latches the value on Confirm and
// issues run/stop commands on Start/Clear.
module keypad_entry_ctrl #(
    parameter int MAX_DIGITS = 3,
    parameter int BIN_W      = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              key_code,
    output logic [4*MAX_DIGITS-1:0] entry_bcd,
    output logic [2:0]              entry_cnt,
    output logic [BIN_W-1:0]        value_bin,
    output logic                    value_valid,
    output logic                    start_pulse,
    output logic                    stop_pulse,
    output logic                    running,
    output logic                    err_pulse
);
    import keypad_pkg::*;

    localparam int         BCD_W   = 4 * MAX_DIGITS;
    localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

    logic             press_evt;
    logic [3:0]       press_code;

    entry_state_e     state_q, state_d;
    logic [BCD_W-1:0] entry_bcd_q, entry_bcd_d;
    logic [2:0]       entry_cnt_q, entry_cnt_d;
    logic [BIN_W-1:0] acc_q, acc_d;
    logic [BIN_W-1:0] value_q, value_d;
    pulse_e           pulse_q, pulse_d;

    // Synchronizer and press-event detector for the raw keypad code.
    key_event_sync u_key_event_sync (
        .clk        (clk),
        .reset      (reset),
        .key_code   (key_code),
        .press_evt  (press_evt),
        .press_code (press_code)
    );

    // FSM next-state, BCD shifter, binary accumulator and pulse selection.
    always_comb begin
        state_d     = state_q;
        entry_bcd_d = entry_bcd_q;
        entry_cnt_d = entry_cnt_q;
        acc_d       = acc_q;
        value_d     = value_q;
        pulse_d     = PL_NONE;

        if (press_evt) begin
            case (classify_key(press_code))
                KC_DIGIT: begin
                    if (state_q == ST_RUN) begin
                        pulse_d = PL_ERR;
                    end else if (state_q == ST_LOCKED) begin
                        // A digit after Confirm starts a fresh entry; the
                        // confirmed value stays on value_bin.
                        entry_bcd_d = BCD_W'(press_code);
                        entry_cnt_d = 3'd1;
                        acc_d       = BIN_W'(press_code);
                        state_d     = ST_ENTRY;
                    end else if (entry_cnt_q < MAX_CNT) begin
                        entry_bcd_d = (entry_bcd_q << 4) | BCD_W'(press_code);
                        entry_cnt_d = entry_cnt_q + 3'd1;
                        // acc*10 + d as two shifts and adds.
                        acc_d       = (acc_q << 3) + (acc_q << 1) + BIN_W'(press_code);
                        state_d     = ST_ENTRY;
                    end else begin
                        pulse_d = PL_ERR;
                    end
                end

                KC_CONFIRM: begin
                    if (state_q == ST_ENTRY) begin
                        // Buffer is kept so the display still shows the value.
                        value_d = acc_q;
                        pulse_d = PL_VALID;
                        state_d = ST_LOCKED;
                    end else begin
                        pulse_d = PL_ERR;
                    end
                end

                KC_START: begin
                    if (state_q == ST_LOCKED) begin
                        pulse_d = PL_START;
                        state_d = ST_RUN;
                    end else begin
                        pulse_d = PL_ERR;
                    end
                end

                KC_CLEAR: begin
                    entry_bcd_d = '0;
                    entry_cnt_d = 3'd0;
                    acc_d       = '0;
                    state_d     = ST_IDLE;
                    if (state_q == ST_RUN) begin
                        pulse_d = PL_STOP;
                    end
                end

                default: begin
                    pulse_d = PL_ERR;
                end
            endcase
        end
    end

    // State and datapath registers; reset drops straight to IDLE with no stop command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            entry_bcd_q <= '0;
            entry_cnt_q <= 3'd0;
            acc_q       <= '0;
            value_q     <= '0;
            pulse_q     <= PL_NONE;
        end else begin
            state_q     <= state_d;
            entry_bcd_q <= entry_bcd_d;
            entry_cnt_q <= entry_cnt_d;
            acc_q       <= acc_d;
            value_q     <= value_d;
            pulse_q     <= pulse_d;
        end
    end

    assign entry_bcd   = entry_bcd_q;
    assign entry_cnt   = entry_cnt_q;
    assign value_bin   = value_q;
    assign running     = (state_q == ST_RUN);
    assign value_valid = (pulse_q == PL_VALID);
    assign start_pulse = (pulse_q == PL_START);
    assign stop_pulse  = (pulse_q == PL_STOP);
    assign err_pulse   = (pulse_q == PL_ERR);

endmodule

// File: doc/keypad_entry_ctrl.md
Name: keypad_entry_ctrl

Overview:
- Downstream consumer of the 4-bit matrix-keypad decoder output (0-9 digits, 0xA start, 0xB clear, 0xC confirm, 0xF no key).
- Turns held/idle key codes into single press events and accumulates up to MAX_DIGITS decimal digits as BCD for display and as binary for the car controller.
- Confirm latches the entered value; Start/Clear issue the run/stop commands to the motion logic.

Parameters:
- MAX_DIGITS, 3, number of decimal digits accepted per entry (1..4).
- BIN_W, 10, width of the binary value; must hold 10^MAX_DIGITS-1.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high reset
- key_code  in  4  keypad decoder output; 0xF = no key; changes slowly and is not synchronous to clk
- entry_bcd  out  4*MAX_DIGITS  digits being typed, least-significant digit in [3:0]
- entry_cnt  out  3  number of digits currently entered (0..MAX_DIGITS)
- value_bin  out  BIN_W  last confirmed value, binary
- value_valid  out  1  one-cycle pulse when value_bin updates
- start_pulse  out  1  one-cycle run command
- stop_pulse  out  1  one-cycle stop command
- running  out  1  high while in RUN
- err_pulse  out  1  one-cycle pulse on a rejected key

Behaviour:
- Reset (async, active-high): entry_bcd=0, entry_cnt=0, value_bin=0, all pulses=0, running=0, state=IDLE, prev_code=0xF.
- Input conditioning: key_code passes through 2 flops (s1, s2). Stable code = s2, accepted only when s1==s2; otherwise prev_code holds.
- Press event: a stable code that differs from prev_code and is not 0xF. prev_code updates on every stable sample.
- A held key gives exactly one event. Release to 0xF re-arms. A direct change from one code to another non-F code is a new event.
- Latency: a key_code value stable before rising edge k produces its outputs or pulses after edge k+3.
- States:
  - IDLE: entry_cnt==0, no locked value.
  - ENTRY: entry_cnt>0.
  - LOCKED: value confirmed, waiting for Start.
  - RUN: running=1.
- Digit event in IDLE, ENTRY, or LOCKED:
  - If entry_cnt<MAX_DIGITS: entry_bcd shifts left by 4 and the new digit enters [3:0]; entry_cnt+1; acc = acc*10 + digit (computed as acc<<3 + acc<<1 + d); state goes to ENTRY. A digit typed in LOCKED starts a new entry: buffer cleared first, then the digit is loaded. value_bin keeps the old value.
  - If entry_cnt==MAX_DIGITS: key ignored, err_pulse.
- Confirm:
  - In ENTRY: value_bin<=acc, value_valid pulse, entry buffer kept for display, state goes to LOCKED.
  - In IDLE or LOCKED: err_pulse, no change.
- Start:
  - In LOCKED: start_pulse, running=1, state goes to RUN.
  - In IDLE or ENTRY: err_pulse.
- Clear:
  - In any state: entry_bcd=0, entry_cnt=0, acc=0, state goes to IDLE. value_bin is retained.
  - If the state was RUN: also stop_pulse and running=0.
- RUN: digit, Confirm, and Start events give err_pulse and nothing else. Only Clear leaves RUN.
- Leading zeros are accepted and counted as digits ("007" gives entry_cnt=3, value 7).
- Undefined codes 0xD and 0xE give err_pulse.
- At most one pulse output is high in any cycle; pulses never last more than one cycle.
- Reset asserted mid-entry or in RUN: immediate return to reset values, with no stop_pulse.

Decomposition:
- Shared package keypad_pkg holds:
  - key code constants: KEY_NONE=4'hF, KEY_START=4'hA, KEY_CLEAR=4'hB, KEY_CONFIRM=4'hC, digit range 0-9
  - entry state encoding (one-hot, 4 states)
- Sub-module key_event_sync holds the 2-flop synchronizer, stability compare, prev_code register, and one-cycle press_evt/press_code outputs.
- keypad_entry_ctrl holds the FSM, BCD shifter, and binary accumulator.

Test Plan:
- Press 1, release, 2, release, 3, release, then Confirm → entry_bcd=0x123, entry_cnt=3, value_bin=123, one value_valid pulse, state LOCKED.
- Hold digit 5 for 10k cycles → one event only: entry_cnt=1, entry_bcd=0x005.
- Enter 9, 9, 9, then 4 → 4 ignored, err_pulse, entry_bcd stays 0x999.
- Enter 4, 2, then Confirm, Start, Clear → value_bin=42, start_pulse at Start, running=1, then stop_pulse and running=0 at Clear; value_bin stays 42.
- Start in IDLE; Confirm with zero digits; digit while running → err_pulse each time, no other output change.
- Assert reset while entry_cnt=2 and while running → all outputs at reset values on the same edge; no pulse emitted.
